// File: rtl/switch_port_tx_if.sv
// switch_port_tx_if: host command/payload handshake plus switch port write bus
interface switch_port_tx_if #(
    parameter int W_WIDTH = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [W_WIDTH-1:0] cmd_addr;
    logic [W_WIDTH-1:0] cmd_len;
    logic               data_valid;
    logic               data_ready;
    logic [W_WIDTH-1:0] data_in;
    logic               port_ready;
    logic               sw_en;
    logic [W_WIDTH-1:0] port_addr;
    logic [W_WIDTH-1:0] port_data;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, data_valid, data_in, port_ready,
        output cmd_ready, data_ready, sw_en, port_addr, port_data
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, data_valid, data_in, port_ready,
        input  cmd_ready, data_ready, sw_en, port_addr, port_data
    );
endinterface

// File: rtl/switch_port_tx.sv
// switch_port_tx: frames host commands into header + payload words for one switch port
module switch_port_tx #(
    parameter int W_WIDTH    = 8,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    switch_port_tx_if.master tx_if,
    output logic             tx_busy_o,
    output logic [CNT_W-1:0] pkt_cnt_o
);
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, GAP} state_e;

    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam state_e DONE_ST = GAP_CYCLES == 0 ? IDLE : GAP;

    state_e             state_q, state_d;
    logic [W_WIDTH-1:0] addr_q, addr_d;
    logic [W_WIDTH-1:0] data_q, data_d;
    logic               en_q, en_d;
    logic [W_WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic               xfer, take, done, start;

    assign xfer  = en_q & tx_if.port_ready;
    assign take  = tx_if.data_valid & tx_if.data_ready;
    assign start = (state_q == IDLE) & tx_if.cmd_valid;
    assign done  = xfer & (rem_q == '0) & ((state_q == HDR) | (state_q == PAYLOAD));

    assign tx_if.sw_en     = en_q;
    assign tx_if.port_addr = addr_q;
    assign tx_if.port_data = data_q;
    assign pkt_cnt_o       = cnt_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            rem_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            en_q    <= en_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    // Next state; a non-empty packet skips HDR so the first payload word can
    // replace the header on its transfer edge without a bubble
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = tx_if.cmd_valid ? (tx_if.cmd_len == '0 ? HDR : PAYLOAD) : IDLE;
            HDR:     state_d = xfer ? (rem_q == '0 ? DONE_ST : PAYLOAD) : HDR;
            PAYLOAD: state_d = done ? DONE_ST : PAYLOAD;
            GAP:     state_d = gap_q == GAP_LAST ? IDLE : GAP;
            default: state_d = IDLE;
        endcase
    end

    // Output register reload, remaining-word count, packet count and gap timer
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        en_d   = en_q;
        rem_d  = rem_q;
        cnt_d  = done ? cnt_q + CNT_W'(1) : cnt_q;
        gap_d  = state_q == GAP ? gap_q + GW'(1) : '0;
        if (start) begin
            addr_d = tx_if.cmd_addr;
            rem_d  = tx_if.cmd_len;
            data_d = tx_if.cmd_len;
            en_d   = 1'b1;
        end else if (take) begin
            data_d = tx_if.data_in;
            en_d   = 1'b1;
            rem_d  = rem_q - W_WIDTH'(1);
        end else if (xfer) begin
            en_d   = 1'b0;
        end
    end

    // Handshake outputs decoded from state; payload is pulled only when the
    // output register is empty or draining this cycle
    always_comb begin
        tx_if.cmd_ready  = state_q == IDLE;
        tx_if.data_ready = (state_q == PAYLOAD) & (rem_q != '0) & (~en_q | tx_if.port_ready);
        tx_busy_o        = state_q != IDLE;
    end
endmodule

// File: tb/tb_switch_port_tx.sv
// tb_switch_port_tx: directed and randomized checks of switch_port_tx against a word-queue model
module tb_switch_port_tx;
    localparam int W   = 8;
    localparam int GAP = 1;
    localparam int CW  = 2;

    typedef struct {logic [7:0] a; logic [7:0] d; bit h; bit last;} wrd_t;
    typedef struct {logic [7:0] a; logic [7:0] len;} cmd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_busy;
    logic [CW-1:0] pkt_cnt;

    switch_port_tx_if #(.W_WIDTH(W)) bus ();

    switch_port_tx #(.W_WIDTH(W), .GAP_CYCLES(GAP), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .tx_if(bus), .tx_busy_o(tx_busy), .pkt_cnt_o(pkt_cnt)
    );

    always #5 clk = ~clk;

    wrd_t       expq[$];
    cmd_t       cmdq[$];
    logic [7:0] hostq[$];
    logic [7:0] srcq[$];
    int         xf_cyc[$];
    int         acc_cyc[$];
    bit         en_tr[$];
    bit         cr_tr[$];
    logic [7:0] addr_tr[$];
    int vectors = 0, miscompares = 0, exp_cnt = 0, cyc_n = 0, dv_pct = 100, pr_pct = 100;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.cmd_valid  = cmdq.size() > 0;
        bus.cmd_addr   = cmdq.size() > 0 ? cmdq[0].a : 8'h00;
        bus.cmd_len    = cmdq.size() > 0 ? cmdq[0].len : 8'h00;
        bus.data_valid = hostq.size() > 0 && $urandom_range(99) < dv_pct;
        bus.data_in    = hostq.size() > 0 ? hostq[0] : 8'($urandom);
        bus.port_ready = $urandom_range(99) < pr_pct;
    endtask

    task automatic cyc();
        wrd_t w;
        cmd_t c;
        logic [7:0] b;
        #3;
        en_tr.push_back(bus.sw_en);
        cr_tr.push_back(bus.cmd_ready);
        addr_tr.push_back(bus.port_addr);
        if (!rst) begin
            if (bus.sw_en && bus.port_ready) begin
                check("word_pending", 32'(expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    w = expq.pop_front();
                    check("port_data", 32'(bus.port_data), 32'(w.d));
                    check("port_addr", 32'(bus.port_addr), 32'(w.a));
                    xf_cyc.push_back(cyc_n);
                    if (w.last) exp_cnt++;
                end
            end
            if (bus.data_ready) check("data_ready_owed", 32'(hostq.size() != 0), 1);
            if (bus.data_valid && bus.data_ready) void'(hostq.pop_front());
            if (bus.cmd_valid && bus.cmd_ready) begin
                c = cmdq.pop_front();
                acc_cyc.push_back(cyc_n);
                w = '{a: c.a, d: c.len, h: 1'b1, last: c.len == 0};
                expq.push_back(w);
                for (int i = 0; i < int'(c.len); i++) begin
                    b = srcq.size() > 0 ? srcq.pop_front() : 8'($urandom);
                    hostq.push_back(b);
                    w = '{a: c.a, d: b, h: 1'b0, last: i == int'(c.len) - 1};
                    expq.push_back(w);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (rst) begin
            exp_cnt = 0;
            expq.delete();
            hostq.delete();
        end
        check("pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt % (1 << CW)));
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            cyc();
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while ((expq.size() != 0 || cmdq.size() != 0) && k < budget) begin
            drive();
            cyc();
            k++;
        end
        check(tag, 32'(expq.size() + cmdq.size()), 0);
        run(4);
    endtask

    initial begin
        int k, a0, c, xf0, held, starved, bub, c0;
        bit forced;
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.data_valid = 1'b0; bus.data_in = '0; bus.port_ready = 1'b0;
        cyc();
        cyc();
        check("rst_sw_en", 32'(bus.sw_en), 0);
        check("rst_port_addr", 32'(bus.port_addr), 0);
        check("rst_port_data", 32'(bus.port_data), 0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_data_ready", 32'(bus.data_ready), 0);
        check("rst_tx_busy", 32'(tx_busy), 0);
        rst = 1'b0;

        // reset on the second payload word of a len-4 packet
        srcq = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        cmdq.push_back('{a: 8'h07, len: 8'd4});
        k = 0;
        while (!(bus.sw_en && bus.port_data == 8'hB2) && k < 20) begin
            drive();
            cyc();
            k++;
        end
        check("reach_b2", 32'(bus.sw_en && bus.port_data == 8'hB2), 1);
        drive();
        rst = 1'b1;
        bus.port_ready = 1'b0;
        cyc();
        rst = 1'b0;
        check("mid_rst_sw_en", 32'(bus.sw_en), 0);
        check("mid_rst_addr", 32'(bus.port_addr), 0);
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("mid_rst_busy", 32'(tx_busy), 0);
        srcq.delete();

        // basic full-throughput packet
        srcq = '{8'hA1, 8'hA2, 8'hA3};
        cmdq.push_back('{a: 8'h02, len: 8'd3});
        a0 = acc_cyc.size();
        run(12);
        check("basic_accept", 32'(acc_cyc.size() - a0), 1);
        if (acc_cyc.size() > a0) begin
            c = acc_cyc[a0];
            for (int j = 1; j <= 4; j++) check("basic_en_run", 32'(en_tr[c + j]), 1);
            check("basic_en_after", 32'(en_tr[c + 5]), 0);
            check("basic_gap_cmd_ready", 32'(cr_tr[c + 5]), 0);
            check("basic_idle_cmd_ready", 32'(cr_tr[c + 6]), 1);
        end

        // backpressure while A2 is presented
        srcq = '{8'hA1, 8'hA2, 8'hA3};
        cmdq.push_back('{a: 8'h02, len: 8'd3});
        held = 0;
        k = 0;
        while ((held < 3 || expq.size() != 0 || cmdq.size() != 0) && k < 40) begin
            drive();
            forced = bus.sw_en && bus.port_data == 8'hA2 && held < 3;
            if (forced) begin
                bus.port_ready = 1'b0;
                held++;
                #1;
                check("bp_data_ready", 32'(bus.data_ready), 0);
            end
            cyc();
            if (forced) begin
                check("bp_hold_data", 32'(bus.port_data), 32'h A2);
                check("bp_hold_en", 32'(bus.sw_en), 1);
                check("bp_hold_addr", 32'(bus.port_addr), 32'h02);
            end
            k++;
        end
        check("bp_held", 32'(held), 3);
        drain("bp_drain", 20);

        // zero-length packet
        cmdq.push_back('{a: 8'h05, len: 8'd0});
        a0 = acc_cyc.size();
        drain("zero_drain", 20);
        check("zero_accept", 32'(acc_cyc.size() - a0), 1);
        if (acc_cyc.size() > a0) begin
            c = acc_cyc[a0];
            check("zero_hdr_en", 32'(en_tr[c + 1]), 1);
            check("zero_after_en", 32'(en_tr[c + 2]), 0);
            check("zero_gap_cmd_ready", 32'(cr_tr[c + 2]), 0);
        end

        // starvation bubble, then a back-to-back command held valid
        srcq = '{8'hC1, 8'hC2, 8'hD1};
        cmdq.push_back('{a: 8'h11, len: 8'd2});
        cmdq.push_back('{a: 8'h12, len: 8'd1});
        xf0 = xf_cyc.size();
        starved = 0;
        k = 0;
        while ((expq.size() != 0 || cmdq.size() != 0) && k < 40) begin
            drive();
            if (hostq.size() != 0 && hostq[0] == 8'hC2 && starved < 2) begin
                bus.data_valid = 1'b0;
                starved++;
            end
            cyc();
            k++;
        end
        run(4);
        check("starve_xfers", 32'(xf_cyc.size() - xf0), 5);
        if (xf_cyc.size() - xf0 == 5) begin
            bub = 0;
            for (int j = xf_cyc[xf0 + 1] + 1; j < xf_cyc[xf0 + 2]; j++) begin
                bub++;
                check("starve_en", 32'(en_tr[j]), 0);
                check("starve_addr", 32'(addr_tr[j]), 32'h11);
            end
            check("starve_bubble", 32'(bub), 2);
            check("b2b_hdr_delay", 32'(xf_cyc[xf0 + 3] - xf_cyc[xf0 + 2]), 32'(GAP + 2));
        end

        // counter wrap with five len-1 packets
        c0 = exp_cnt;
        for (int i = 0; i < 5; i++) cmdq.push_back('{a: 8'(8'h20 + i), len: 8'd1});
        drain("wrap_drain", 100);
        check("wrap_final", 32'(pkt_cnt), 32'((c0 + 5) % (1 << CW)));

        // randomized traffic with random valid/ready, including maximum length
        dv_pct = 70;
        pr_pct = 60;
        for (int i = 0; i < 30; i++) cmdq.push_back('{a: 8'($urandom), len: 8'($urandom_range(12))});
        cmdq.push_back('{a: 8'hAA, len: 8'd255});
        for (int i = 0; i < 5; i++) cmdq.push_back('{a: 8'($urandom), len: 8'($urandom_range(3))});
        drain("rand_drain", 20000);
        check("rand_idle_busy", 32'(tx_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
